// File: rtl/sobol_deser_if.sv
// Bundles the serial link, the word handshake and the status pulses of sobol_deser.
interface sobol_deser_if;
  logic       ser_en;
  logic       ser_bit;
  logic       word_ready;
  logic       word_valid;
  logic [5:0] word_data;
  logic [4:0] word_idx;
  logic [2:0] level;
  logic       err_short;
  logic       err_long;
  logic       ovf;

  // Transmitter/consumer side
  modport master (
    output ser_en, ser_bit, word_ready,
    input  word_valid, word_data, word_idx, level, err_short, err_long, ovf
  );

  // Receiver side
  modport slave (
    input  ser_en, ser_bit, word_ready,
    output word_valid, word_data, word_idx, level, err_short, err_long, ovf
  );
endinterface

// File: rtl/sobol_deser.sv
// Sobol bit-serial receiver: rebuilds LSB-first 6-bit frames, tags each word
// with a 5-bit sequence index and queues it in a 4-entry valid/ready FIFO.
module sobol_deser (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  sobol_deser_if.slave bus
);
  localparam int unsigned FRAME_BITS = 6;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, DRAIN} state_t;

  state_t      state_q;
  logic [5:0]  sr_q;
  logic [2:0]  bc_q;
  logic [4:0]  seq_q;
  logic        err_short_q, err_long_q, ovf_q;

  logic [10:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  logic [AW:0] level_w;
  logic        full_w, pop_w, push_w, accept_w;
  logic [10:0] push_word_w;

  assign level_w     = wr_ptr_q - rd_ptr_q;
  assign full_w      = (level_w == (AW+1)'(FIFO_DEPTH));
  assign pop_w       = (wr_ptr_q != rd_ptr_q) && bus.word_ready;
  assign push_w      = (state_q == SHIFT) && bus.ser_en && (bc_q == 3'(FRAME_BITS - 1));
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign accept_w    = push_w && (!full_w || pop_w);
  assign push_word_w = {seq_q, bus.ser_bit, sr_q[4:0]};

  // Framing FSM with shift register, bit/sequence counters and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bc_q        <= '0;
      seq_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (!en) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bc_q        <= '0;
      seq_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      ovf_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ser_en) begin
            sr_q[0] <= bus.ser_bit;
            bc_q    <= 3'd1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.ser_en) begin
            if (bc_q == 3'(FRAME_BITS - 1)) begin
              seq_q   <= seq_q + 5'd1;
              ovf_q   <= !accept_w;
              bc_q    <= '0;
              state_q <= DONE;
            end else begin
              sr_q[bc_q] <= bus.ser_bit;
              bc_q       <= bc_q + 3'd1;
            end
          end else begin
            err_short_q <= 1'b1;
            sr_q        <= '0;
            bc_q        <= '0;
            state_q     <= IDLE;
          end
        end
        DONE: begin
          if (bus.ser_en) begin
            err_long_q <= 1'b1;
            state_q    <= DRAIN;
          end else begin
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (!bus.ser_en) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output FIFO storage and pointers; occupancy is the pointer difference
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (!en) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept_w) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_word_w;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_w) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign bus.word_valid = (wr_ptr_q != rd_ptr_q);
  assign bus.word_data  = mem_q[rd_ptr_q[AW-1:0]][5:0];
  assign bus.word_idx   = mem_q[rd_ptr_q[AW-1:0]][10:6];
  assign bus.level      = level_w;
  assign bus.err_short  = err_short_q;
  assign bus.err_long   = err_long_q;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_sobol_deser.sv
// Bench for sobol_deser: directed scenarios plus random framing traffic,
// compared every cycle against a run-length/queue reference model.
module tb_sobol_deser;
  logic clk = 1'b0;
  logic rst;
  logic en;

  sobol_deser_if bus ();

  sobol_deser dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] idx;
    logic [5:0] data;
  } word_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  word_t       mq[$];
  int          run_len;
  int unsigned m_seq;
  logic [5:0]  acc;
  bit          exp_short, exp_long, exp_ovf;
  int          rmode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_seq     = 0;
    run_len   = 0;
    acc       = '0;
    exp_short = 0;
    exp_long  = 0;
    exp_ovf   = 0;
  endtask

  // Reference: a frame is a run of consecutive high ser_en cycles; the 6th
  // cycle of a run completes a word, a 7th flags err_long, a run ending
  // after 1..5 cycles flags err_short.
  task automatic model_edge(input bit e, input bit b, input bit r, input bit en_v);
    bit    pop, full, push;
    word_t w;
    exp_short = 0;
    exp_long  = 0;
    exp_ovf   = 0;
    if (!en_v) begin
      model_clear();
      return;
    end
    pop  = (mq.size() > 0) && r;
    full = (mq.size() == 4);
    push = 0;
    if (e) begin
      run_len++;
      if (run_len <= 6) acc[run_len-1] = b;
      if (run_len == 6) begin
        w.idx  = 5'(m_seq);
        w.data = acc;
        m_seq  = (m_seq + 1) % 32;
        if (full && !pop) exp_ovf = 1;
        else push = 1;
      end
      if (run_len == 7) exp_long = 1;
    end else begin
      if (run_len >= 1 && run_len <= 5) exp_short = 1;
      run_len = 0;
    end
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(w);
  endtask

  task automatic check_outputs();
    check("word_valid", 32'(bus.word_valid), 32'(mq.size() != 0));
    check("level",      32'(bus.level),      32'(mq.size()));
    check("err_short",  32'(bus.err_short),  32'(exp_short));
    check("err_long",   32'(bus.err_long),   32'(exp_long));
    check("ovf",        32'(bus.ovf),        32'(exp_ovf));
    if (mq.size() != 0) begin
      check("word_data", 32'(bus.word_data), 32'(mq[0].data));
      check("word_idx",  32'(bus.word_idx),  32'(mq[0].idx));
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, update model, compare
  task automatic step(input bit e, input bit b);
    bit r;
    r = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    bus.ser_en     = e;
    bus.ser_bit    = b;
    bus.word_ready = r;
    @(posedge clk);
    model_edge(e, b, r, en);
    #1;
    check_outputs();
  endtask

  task automatic send_frame(input logic [5:0] d, input int gap);
    logic [5:0] v;
    v = d;
    for (int i = 0; i < 6; i++) step(1'b1, v[i]);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
  endtask

  task automatic en_pulse();
    en = 1'b0;
    step(1'b0, 1'b0);
    en = 1'b1;
  endtask

  initial begin
    logic [5:0] v;
    bus.ser_en     = 1'b0;
    bus.ser_bit    = 1'b0;
    bus.word_ready = 1'b0;
    en             = 1'b1;
    rst            = 1'b0;
    rmode          = 0;
    model_clear();

    // Reset values held while rst is low
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.word_valid), 32'd0);
    check("rst_data",  32'(bus.word_data),  32'd0);
    check("rst_idx",   32'(bus.word_idx),   32'd0);
    check("rst_level", 32'(bus.level),      32'd0);
    check("rst_short", 32'(bus.err_short),  32'd0);
    check("rst_long",  32'(bus.err_long),   32'd0);
    check("rst_ovf",   32'(bus.ovf),        32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // Single frame 1,0,1,1,0,0 -> 0x0D, index 0
    send_frame(6'h0D, 1);
    check("single_data",  32'(bus.word_data),  32'h0D);
    check("single_idx",   32'(bus.word_idx),   32'd0);
    check("single_level", 32'(bus.level),      32'd1);
    check("single_valid", 32'(bus.word_valid), 32'd1);
    rmode = 1;
    step(1'b0, 1'b0);
    check("single_popped", 32'(bus.word_valid), 32'd0);

    // 33-word sweep from a cleared sequence counter: index wraps to 0
    en_pulse();
    rmode = 1;
    for (int i = 0; i < 32; i++) send_frame(6'(i), 1);
    for (int i = 0; i < 6; i++) step(1'b1, (i == 0 || i == 2));
    check("wrap_idx",  32'(bus.word_idx),  32'd0);
    check("wrap_data", 32'(bus.word_data), 32'd5);
    step(1'b0, 1'b0);

    // Short frame, then overrun of 9 cycles, then a good frame
    rmode = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("short_pulse", 32'(bus.err_short), 32'd1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);
    send_frame(6'h2A, 2);
    rmode = 1;
    repeat (4) step(1'b0, 1'b0);

    // Overflow: five frames into a stalled FIFO, then drain, then index 5
    en_pulse();
    rmode = 0;
    for (int i = 0; i < 4; i++) send_frame(6'(10 + i), 1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check("ovf_pulse", 32'(bus.ovf),   32'd1);
    check("ovf_level", 32'(bus.level), 32'd4);
    step(1'b0, 1'b0);
    rmode = 1;
    for (int i = 0; i < 4; i++) begin
      check("drain_idx", 32'(bus.word_idx), 32'(i));
      step(1'b0, 1'b0);
    end
    rmode = 0;
    send_frame(6'h33, 1);
    check("after_ovf_idx", 32'(bus.word_idx), 32'd5);

    // Full FIFO with pop coinciding with the final frame bit
    en_pulse();
    rmode = 0;
    for (int i = 0; i < 4; i++) send_frame(6'(20 + i), 1);
    v = 6'h3C;
    for (int i = 0; i < 5; i++) step(1'b1, v[i]);
    rmode = 1;
    step(1'b1, v[5]);
    rmode = 0;
    check("fullpop_ovf",   32'(bus.ovf),   32'd0);
    check("fullpop_level", 32'(bus.level), 32'd4);
    step(1'b0, 1'b0);

    // en dropped during bit 3: everything cleared, no error pulse
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    en = 1'b0;
    step(1'b1, 1'b1);
    en = 1'b1;
    check("endrop_level", 32'(bus.level), 32'd0);
    step(1'b0, 1'b0);
    check("endrop_short", 32'(bus.err_short), 32'd0);
    send_frame(6'h11, 1);
    check("endrop_idx", 32'(bus.word_idx), 32'd0);

    // Random traffic: mostly good frames, some short/long, random ready
    rmode = 2;
    for (int n = 0; n < 300; n++) begin
      int kind, len, gap;
      kind = $urandom_range(0, 99);
      len  = (kind < 80) ? 6 : (kind < 90) ? $urandom_range(1, 5) : $urandom_range(7, 10);
      gap  = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 1)));
      for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
      if ($urandom_range(0, 49) == 0) en_pulse();
    end
    rmode = 1;
    repeat (6) step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
